// File: rtl/native_bus_dma_pkg.sv
// native_bus_dma_pkg: shared FSM states and bus constants for the word-copy DMA.
package native_bus_dma_pkg;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, FINISH} state_t;
  localparam logic [3:0] WSTRB_FULL = 4'hF;
  localparam logic [3:0] WSTRB_NONE = 4'h0;
  localparam logic [31:0] WORD_BYTES = 32'd4;
endpackage

// File: rtl/native_bus_dma.sv
// native_bus_dma: copies cfg_len 32-bit words from cfg_src to cfg_dst over a native
// valid/ready bus, one read then one write per word, with sticky abort.
module native_bus_dma
  import native_bus_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [31:0]      cfg_src,
  input  logic [31:0]      cfg_dst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic             mem_valid,
  output logic             mem_instr,
  input  logic             mem_ready,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic [3:0]       mem_wstrb,
  input  logic [31:0]      mem_rdata
);
  state_t r_state, w_next;
  logic [31:0] r_src, r_dst, r_data;
  logic [LEN_W-1:0] r_len, r_idx;
  logic r_abort, r_error;
  logic w_misaligned, w_abort;
  assign w_misaligned = |{cfg_src[1:0], cfg_dst[1:0]};
  assign w_abort = r_abort | cfg_abort;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cfg_start && !w_misaligned) w_next = (cfg_len == '0) ? FINISH : RD_REQ;
      RD_REQ:  if (mem_ready) w_next = RD_GAP;
      RD_GAP:  w_next = w_abort ? FINISH : WR_REQ;
      WR_REQ:  if (mem_ready) w_next = WR_GAP;
      WR_GAP:  w_next = (w_abort || r_idx == r_len) ? FINISH : RD_REQ;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_data  <= '0;
      r_abort <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_next;
      r_error <= r_state == IDLE && cfg_start && w_misaligned;
      r_abort <= busy && w_abort;
      if (r_state == IDLE) begin
        r_src <= cfg_src;
        r_dst <= cfg_dst;
        r_len <= cfg_len;
        r_idx <= '0;
      end
      if (r_state == RD_REQ && mem_ready) r_data <= mem_rdata;
      if (r_state == WR_REQ && mem_ready) r_idx <= r_idx + 1'b1;
    end
  end
  // Bus outputs decode the state directly, so they stay frozen for the whole request
  assign busy      = !(r_state == IDLE || r_state == FINISH);
  assign done      = r_state == FINISH;
  assign error     = r_error;
  assign mem_instr = 1'b0;
  assign mem_valid = r_state == RD_REQ || r_state == WR_REQ;
  assign mem_addr  = (r_state == RD_REQ) ? r_src + 32'(r_idx) * WORD_BYTES :
                     (r_state == WR_REQ) ? r_dst + 32'(r_idx) * WORD_BYTES : '0;
  assign mem_wstrb = (r_state == WR_REQ) ? WSTRB_FULL : WSTRB_NONE;
  assign mem_wdata = (r_state == WR_REQ) ? r_data : '0;
endmodule

// File: tb/tb_native_bus_dma.sv
// tb_native_bus_dma: directed checks of native_bus_dma against a latency-programmable responder.
module tb_native_bus_dma;
  logic clk = 1'b0;
  logic resetn;
  logic [31:0] cfg_src, cfg_dst;
  logic [15:0] cfg_len;
  logic cfg_start, cfg_abort;
  logic busy, done, error, mem_valid, mem_instr, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  logic r_ready = 1'b0, tb_ready;
  logic [31:0] r_rdata = '0;
  int lat, rcnt = 0;
  int n_checks = 0, n_err = 0;
  int nrd = 0, nwr = 0, nvalid = 0, unstable = 0;
  logic [31:0] rd_addr [64];
  logic [31:0] wr_addr [64];
  logic [31:0] wr_data [64];
  logic [3:0]  wr_strb [64];
  logic prev_v = 1'b0, prev_hs = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic [3:0] p_wstrb = '0;

  native_bus_dma #(.LEN_W(16)) dut (
    .clk(clk), .resetn(resetn), .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .busy(busy), .done(done), .error(error),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_ready = r_ready | tb_ready;
  assign mem_rdata = r_rdata;

  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Responder: ready after the request has been valid for lat full cycles
  always @(negedge clk) begin
    if (mem_valid && !r_ready) begin
      if (rcnt >= lat) begin
        r_ready = 1'b1;
        r_rdata = f(mem_addr);
      end else rcnt++;
    end else begin
      r_ready = 1'b0;
      rcnt = 0;
    end
  end

  always @(posedge clk) begin
    if (mem_valid) nvalid++;
    if (mem_valid && prev_hs) unstable++;
    if (mem_valid && prev_v && !prev_hs &&
        (mem_addr !== p_addr || mem_wstrb !== p_wstrb || mem_wdata !== p_wdata)) unstable++;
    if (mem_valid && mem_ready) begin
      if (mem_wstrb != 4'h0) begin
        wr_addr[nwr[5:0]] = mem_addr;
        wr_data[nwr[5:0]] = mem_wdata;
        wr_strb[nwr[5:0]] = mem_wstrb;
        nwr++;
      end else begin
        rd_addr[nrd[5:0]] = mem_addr;
        nrd++;
      end
    end
    prev_v = mem_valid;
    prev_hs = mem_valid && mem_ready;
    p_addr = mem_addr;
    p_wstrb = mem_wstrb;
    p_wdata = mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    cfg_src = s;
    cfg_dst = d;
    cfg_len = l;
    cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(output int c);
    c = 0;
    while (!done && c < 200) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    int c, bw, br, v, u;
    resetn = 1'b0; cfg_src = '0; cfg_dst = '0; cfg_len = '0;
    cfg_start = 1'b0; cfg_abort = 1'b0; tb_ready = 1'b0; lat = 1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_valid", mem_valid, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wstrb", mem_wstrb, 0);
    check("rst_wdata", mem_wdata, 0);
    check("instr", mem_instr, 0);
    resetn = 1'b1;
    @(negedge clk);
    // basic 3-word copy
    br = nrd; bw = nwr;
    start_copy(32'h100, 32'h200, 3);
    check("t1_busy", busy, 1);
    check("t1_valid", mem_valid, 1);
    check("t1_addr0", mem_addr, 32'h100);
    check("t1_rd_wstrb", mem_wstrb, 0);
    wait_done(c);
    check("t1_done", done, 1);
    check("t1_latency", c, 18);
    check("t1_busy_fin", busy, 0);
    check("t1_reads", nrd - br, 3);
    check("t1_writes", nwr - bw, 3);
    for (int i = 0; i < 3; i++) begin
      check("t1_rd_addr", rd_addr[br + i], 32'h100 + 4 * i);
      check("t1_wr_addr", wr_addr[bw + i], 32'h200 + 4 * i);
      check("t1_wr_data", wr_data[bw + i], f(32'h100 + 4 * i));
      check("t1_wr_strb", wr_strb[bw + i], 4'hF);
    end
    @(negedge clk);
    check("t1_done_pulse", done, 0);
    check("t1_idle_busy", busy, 0);
    // zero length and misaligned starts
    v = nvalid;
    start_copy(32'h100, 32'h200, 0);
    check("t2_len0_done", done, 1);
    check("t2_len0_busy", busy, 0);
    check("t2_len0_err", error, 0);
    @(negedge clk);
    check("t2_len0_done_pulse", done, 0);
    start_copy(32'h102, 32'h200, 5);
    check("t2_mis_err", error, 1);
    check("t2_mis_done", done, 0);
    check("t2_mis_busy", busy, 0);
    @(negedge clk);
    check("t2_mis_err_pulse", error, 0);
    start_copy(32'h100, 32'h203, 0);
    check("t2_mis_len0_err", error, 1);
    check("t2_mis_len0_done", done, 0);
    @(negedge clk);
    check("t2_no_valid", nvalid - v, 0);
    // slow responder
    lat = 5; v = nvalid; bw = nwr; u = unstable;
    start_copy(32'h300, 32'h400, 1);
    wait_done(c);
    check("t3_done", done, 1);
    check("t3_latency", c, 14);
    check("t3_valid_cycles", nvalid - v, 12);
    check("t3_stable", unstable - u, 0);
    check("t3_wr_addr", wr_addr[bw], 32'h400);
    check("t3_wr_data", wr_data[bw], f(32'h300));
    lat = 1;
    @(negedge clk);
    // abort during second read
    br = nrd; bw = nwr;
    start_copy(32'h500, 32'h600, 4);
    repeat (6) @(negedge clk);
    check("t4_rd1_addr", mem_addr, 32'h504);
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    check("t4_valid_held", mem_valid, 1);
    wait_done(c);
    check("t4_done", done, 1);
    check("t4_abort_lat", c, 2);
    check("t4_busy", busy, 0);
    check("t4_reads", nrd - br, 2);
    check("t4_writes", nwr - bw, 1);
    @(negedge clk);
    cfg_abort = 1'b1;
    @(negedge clk);
    cfg_abort = 1'b0;
    bw = nwr;
    start_copy(32'h540, 32'h640, 1);
    wait_done(c);
    check("t4_idle_abort_writes", nwr - bw, 1);
    @(negedge clk);
    bw = nwr;
    cfg_abort = 1'b1;
    start_copy(32'h580, 32'h680, 2);
    cfg_abort = 1'b0;
    wait_done(c);
    check("t4_start_abort_lat", c, 12);
    check("t4_start_abort_writes", nwr - bw, 2);
    @(negedge clk);
    // reset during write of word 1
    bw = nwr;
    start_copy(32'h700, 32'h800, 3);
    repeat (9) @(negedge clk);
    check("t5_wr1_addr", mem_addr, 32'h804);
    check("t5_wr1_strb", mem_wstrb, 4'hF);
    resetn = 1'b0;
    @(negedge clk);
    check("t5_rst_valid", mem_valid, 0);
    check("t5_rst_busy", busy, 0);
    resetn = 1'b1;
    @(negedge clk);
    tb_ready = 1'b1;
    @(negedge clk);
    tb_ready = 1'b0;
    check("t5_stray_valid", mem_valid, 0);
    check("t5_stray_busy", busy, 0);
    check("t5_stray_done", done, 0);
    check("t5_writes", nwr - bw, 1);
    bw = nwr;
    start_copy(32'h900, 32'hA00, 2);
    wait_done(c);
    check("t5_re_done", done, 1);
    check("t5_re_writes", nwr - bw, 2);
    for (int i = 0; i < 2; i++) begin
      check("t5_re_wr_addr", wr_addr[bw + i], 32'hA00 + 4 * i);
      check("t5_re_wr_data", wr_data[bw + i], f(32'h900 + 4 * i));
    end
    @(negedge clk);
    // address wrap and ignored restart
    br = nrd; bw = nwr;
    start_copy(32'hFFFF_FFF8, 32'h1000, 3);
    start_copy(32'h2000, 32'h3000, 1);
    wait_done(c);
    check("t6_latency", c, 17);
    check("t6_reads", nrd - br, 3);
    check("t6_writes", nwr - bw, 3);
    check("t6_rd0", rd_addr[br], 32'hFFFF_FFF8);
    check("t6_rd1", rd_addr[br + 1], 32'hFFFF_FFFC);
    check("t6_rd2", rd_addr[br + 2], 32'h0000_0000);
    check("t6_wr2_addr", wr_addr[bw + 2], 32'h1008);
    check("t6_wr2_data", wr_data[bw + 2], f(32'h0));
    @(negedge clk);
    check("bus_stable", unstable, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
